// File: rtl/shift_arb_if.sv
// Request/response bundle between the two requesters and shift_arbiter.
// The master side is the requester pair; the slave side is the arbiter.
interface shift_arb_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [4:0]  req_shamt0;
    logic [4:0]  req_shamt1;
    logic [1:0]  req_type0;
    logic [1:0]  req_type1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    modport master (
        output req_valid, req_a0, req_a1, req_shamt0, req_shamt1,
               req_type0, req_type1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a0, req_a1, req_shamt0, req_shamt1,
               req_type0, req_type1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// Shares one 32-bit shifter between two requesters, one operation in flight.
// Define SHIFT_ARB_RR_EN for round-robin ties; otherwise requester 0 has priority.
module shift_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    shift_arb_if.slave  bus_io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [1:0]  type_q, type_d;
    logic        gnt_id_q, gnt_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        busy_q;
    logic        win_s;
    logic [1:0]  req_ready_s;
    logic [31:0] shift_s;
`ifdef SHIFT_ARB_RR_EN
    logic        last_gnt_q, last_gnt_d;
`endif

    function automatic logic [31:0] shift_fn(input logic [31:0] a,
                                             input logic [4:0]  sh,
                                             input logic [1:0]  t);
        logic [31:0] r;
        r = 32'h0000_0000;
        case (t)
            2'b00:   r = a << sh;
            2'b01:   r = a >> sh;
            2'b10:   r = $unsigned($signed(a) >>> sh);
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // The shared shifter only ever sees the captured operands.
    assign shift_s = shift_fn(a_q, shamt_q, type_q);

    // Winner selection among valid requesters.
    always_comb begin
        win_s = 1'b0;
`ifdef SHIFT_ARB_RR_EN
        if (bus_io.req_valid == 2'b11) begin
            win_s = ~last_gnt_q;
        end else if (bus_io.req_valid[1]) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`else
        if (bus_io.req_valid[0]) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`endif
    end

    // Sequencer next-state and datapath capture.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        shamt_d     = shamt_q;
        type_d      = type_q;
        gnt_id_d    = gnt_id_q;
        rsp_data_d  = rsp_data_q;
        req_ready_s = 2'b00;
`ifdef SHIFT_ARB_RR_EN
        last_gnt_d  = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus_io.req_valid) begin
                    req_ready_s[win_s] = 1'b1;
                    a_d      = win_s ? bus_io.req_a1     : bus_io.req_a0;
                    shamt_d  = win_s ? bus_io.req_shamt1 : bus_io.req_shamt0;
                    type_d   = win_s ? bus_io.req_type1  : bus_io.req_type0;
                    gnt_id_d = win_s;
`ifdef SHIFT_ARB_RR_EN
                    last_gnt_d = win_s;
`endif
                    state_d  = EXEC;
                end else begin
                    state_d  = IDLE;
                end
            end
            EXEC: begin
                rsp_data_d = shift_s;
                state_d    = RESP;
            end
            RESP: begin
                if (bus_io.rsp_ready[gnt_id_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, result and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= 32'h0000_0000;
            shamt_q    <= 5'd0;
            type_q     <= 2'b00;
            gnt_id_q   <= 1'b0;
            rsp_data_q <= 32'h0000_0000;
            busy_q     <= 1'b0;
`ifdef SHIFT_ARB_RR_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            shamt_q    <= shamt_d;
            type_q     <= type_d;
            gnt_id_q   <= gnt_id_d;
            rsp_data_q <= rsp_data_d;
            busy_q     <= (state_d != IDLE);
`ifdef SHIFT_ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    // Grant is gated by reset so a request seen during reset is never accepted.
    assign bus_io.req_ready = rst_n ? req_ready_s : 2'b00;
    assign bus_io.rsp_valid = (state_q == RESP) ? (gnt_id_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus_io.rsp_data  = rsp_data_q;
    assign bus_io.busy      = busy_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: random and directed requests, per-requester
// expected-result queues filled at acceptance and drained by a response monitor.
module tb_shift_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    shift_arb_if bus();

    shift_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q[2][$];
    int          grant_log[$];
    logic [31:0] cur_a[2];
    logic [4:0]  cur_sh[2];
    logic [1:0]  cur_t[2];

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                              input logic [1:0] t);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        if (t == 2'b00) return a << sh;
        if (t == 2'b01) return a >> sh;
        if (t == 2'b10) return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
        return 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic drive_op(input int i, input logic [31:0] a, input logic [4:0] sh,
                            input logic [1:0] t);
        cur_a[i] = a; cur_sh[i] = sh; cur_t[i] = t;
        if (i == 0) begin
            bus.req_a0 = a; bus.req_shamt0 = sh; bus.req_type0 = t;
        end else begin
            bus.req_a1 = a; bus.req_shamt1 = sh; bus.req_type1 = t;
        end
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic new_op(input int i);
        drive_op(i, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    endtask

    // One cycle of the random driver: record acceptances, then refresh inputs.
    task automatic step(input int p_new, input int p_ready);
        bit acc[2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            acc[i] = 1'b0;
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                exp_q[i].push_back(ref_shift(cur_a[i], cur_sh[i], cur_t[i]));
                grant_log.push_back(i);
                acc[i] = 1'b1;
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) bus.req_valid[i] = 1'b0;
            if (!bus.req_valid[i] && ($urandom_range(0, 99) < p_new)) new_op(i);
            bus.rsp_ready[i] = ($urandom_range(0, 99) < p_ready);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.req_valid == 2'b00 && exp_q[0].size() == 0 && exp_q[1].size() == 0
                && !bus.busy) begin
                done = 1'b1;
                break;
            end
            step(0, 100);
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_accept(input int i, output bit got);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready[i]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Directed op with fixed expected result and exact latency checks.
    task automatic issue_dir(input int i, input logic [31:0] a, input logic [4:0] sh,
                             input logic [1:0] t, input logic [31:0] expv);
        bit got;
        bus.rsp_ready = 2'b11;
        drive_op(i, a, sh, t);
        wait_accept(i, got);
        if (got) exp_q[i].push_back(expv);
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
        @(negedge clk);
        chk("lat_exec_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("lat_exec_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("lat_resp_rsp_valid", {30'd0, bus.rsp_valid}, (i == 0) ? 32'd1 : 32'd2);
        @(negedge clk);
        chk("after_rsp_idle_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("after_rsp_idle_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Response monitor: every presented result must be one the scoreboard expects.
    always @(negedge clk) begin
        if (rst_n) begin
            if (|bus.req_ready)
                chk("req_ready_onehot", {31'd0, $onehot(bus.req_ready)}, 32'd1);
            for (int i = 0; i < 2; i++) begin
                if (bus.rsp_valid[i]) begin
                    if (exp_q[i].size() == 0)
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    else if (bus.rsp_ready[i])
                        chk("rsp_data", bus.rsp_data, exp_q[i].pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        bus.req_a0 = 32'h0; bus.req_a1 = 32'h0;
        bus.req_shamt0 = 5'd0; bus.req_shamt1 = 5'd0;
        bus.req_type0 = 2'b00; bus.req_type1 = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue_dir(0, 32'hF000_000F, 5'd4, 2'b00, 32'h0000_00F0);
        issue_dir(1, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
        issue_dir(1, 32'h8000_0000, 5'd31, 2'b11, 32'h0000_0000);
        issue_dir(0, 32'h1234_5678, 5'd0, 2'b01, 32'h1234_5678);

        repeat (400) step(40, 70);
        drain();

        // Backpressure: requester 0 held in RESP while requester 1 waits.
        bus.rsp_ready = 2'b00;
        new_op(0);
        wait_accept(0, got);
        if (got) exp_q[0].push_back(ref_shift(cur_a[0], cur_sh[0], cur_t[0]));
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        new_op(1);
        bus.rsp_ready = 2'b10;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
            chk("bp_rsp_data", bus.rsp_data, (exp_q[0].size() > 0) ? exp_q[0][0] : 32'hDEAD_BEEF);
            chk("bp_req_ready", {30'd0, bus.req_ready}, 32'd0);
            chk("bp_busy", {31'd0, bus.busy}, 32'd1);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 2'b01;
        @(posedge clk); #1;
        chk("bp_done_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("bp_done_busy", {31'd0, bus.busy}, 32'd0);
        drain();

        // Asynchronous reset while requester 0's operation is in EXEC.
        bus.rsp_ready = 2'b11;
        new_op(0);
        wait_accept(0, got);
        @(posedge clk); #2;
        new_op(0);
        new_op(1);
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        chk("midrst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("midrst_rsp_data", bus.rsp_data, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        exp_q[0].delete();
        exp_q[1].delete();
        grant_log.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention: both requesters stay valid from the first cycle after reset.
        for (int k = 0; k < 40; k++) begin
            if (grant_log.size() >= 4) break;
            step(100, 100);
        end
        chk("cont_grant_count", (grant_log.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        for (int j = 0; j < 4; j++) begin
            if (j < grant_log.size()) begin
`ifdef SHIFT_ARB_RR_EN
                chk("cont_grant", grant_log[j], j % 2);
`else
                chk("cont_grant", grant_log[j], 32'd0);
`endif
            end
        end
        drain();

        repeat (300) step(60, 50);
        drain();
        chk("final_q0_empty", exp_q[0].size(), 32'd0);
        chk("final_q1_empty", exp_q[1].size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one instance of the team's 32-bit combinational `shifter` between two requesters, such as an integer issue port and a CSR/debug port. It uses a valid/ready request handshake per requester, a three-state sequencer, and a registered, held response per requester. The block sits between the requesters and the shifter so that only one shift is in flight at a time.

## Interface
Parameters:
- none; all widths are fixed at 32-bit data, 5-bit shamt and 2-bit type.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid[1:0]`  in  2  request valid; bit i belongs to requester i.
- `req_ready[1:0]`  out  2  request accepted this cycle; at most one bit is high.
- `req_a0`, `req_a1`  in  32  operand for requester 0 and requester 1.
- `req_shamt0`, `req_shamt1`  in  5  shift amount.
- `req_type0`, `req_type1`  in  2  shift type: 00 SLL, 01 SRL, 10 SRA, 11 result zero.
- `rsp_valid[1:0]`  out  2  result valid for requester i.
- `rsp_ready[1:0]`  in  2  requester i consumes the result.
- `rsp_data`  out  32  result register, shared by both requesters; meaningful only while a `rsp_valid` bit is high.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: no operation in flight.
  - EXEC: the shifter computes from the captured operands.
  - RESP: the result is held for the granted requester.
- IDLE:
  - If any `req_valid` is high, select a winner g.
  - Drive `req_ready[g]`=1 combinationally in this cycle.
  - At the clock edge, capture the winner's a/shamt/type into operand registers, record g in `gnt_id`, and go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC:
  - The shifter inputs come only from the operand registers, never directly from the ports.
  - At the clock edge, register the shifter output into `rsp_data` and go to RESP.
- RESP:
  - `rsp_valid[gnt_id]`=1 and `rsp_data` is held stable.
  - When `rsp_ready[gnt_id]`=1 at an edge, go to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- `req_ready` is 0 in EXEC and RESP. Requests arriving then wait, and the requester must hold its operands stable while waiting.
- Arithmetic matches the shifter exactly:
  - SLL and SRL zero-fill.
  - SRA replicates bit 31.
  - shamt=0 passes the operand through unchanged.
  - type 11 yields 32'h0.
- Reset, including mid-operation:
  - Return to IDLE; the in-flight result is discarded and never presented.
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
  - `gnt_id`=0 and the round-robin pointer `last_gnt`=1.

## Timing
- A request is accepted at edge N when it is valid and ready in the cycle before that edge.
- State is EXEC in cycle N+1 and RESP in cycle N+2, so `rsp_valid` first goes high in cycle N+2 (2-cycle latency).
- If `rsp_ready` is already high in cycle N+2, the block is back in IDLE in cycle N+3. A new acceptance can occur at edge N+3, so minimum occupancy is 3 cycles per operation.
- Response backpressure is unbounded: RESP holds `rsp_valid` and `rsp_data` indefinitely.
- Simultaneous request and reset: reset wins and the request is not accepted.
- `busy` is registered and equals (state != IDLE).

## Configuration
- `SHIFT_ARB_RR_EN` defined: round-robin arbitration.
  - When both requesters are valid in IDLE, grant the one not equal to `last_gnt`.
  - `last_gnt` updates to g on every acceptance.
  - With a lone request, the lone requester wins regardless of `last_gnt`.
- `SHIFT_ARB_RR_EN` undefined: fixed priority; requester 0 always wins a tie.
  - `last_gnt` is not implemented.
  - All other behaviour is identical.

## Test plan
- Single request: requester 0 with a=32'hF000_000F, shamt=4, type=00, `rsp_ready`=1 -> `rsp_valid[0]` high exactly 2 cycles after acceptance, `rsp_data`=32'h0000_00F0, IDLE on the next cycle.
- SRA and type 11:
  - requester 1 with a=32'h8000_0000, shamt=31, type=10 -> 32'hFFFF_FFFF.
  - same operand with type=11 -> 32'h0.
  - shamt=0, type=01, a=32'h1234_5678 -> 32'h1234_5678.
- Contention: both valid continuously, each with distinct operands.
  - With `SHIFT_ARB_RR_EN` defined: grants alternate 0,1,0,1 starting with 0.
  - Without the macro: requester 0 is granted every time and requester 1 starves while requester 0 stays valid.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in RESP.
  - `rsp_valid` and `rsp_data` stay stable.
  - `req_ready`=00 and `busy`=1 throughout.
  - Completion happens on the first edge with `rsp_ready`=1.
- Reset mid-operation: assert `rst_n`=0 asynchronously during EXEC.
  - All outputs go to 0 immediately.
  - After release, no stale response ever appears.
  - With `SHIFT_ARB_RR_EN` defined, the next tie grants requester 0.
